// File: rtl/chmod_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : chmod_pkg
//  Purpose  : Shared constants, trig table generator and output rounding for
//             the receive channel demodulator.
//  Revision : 1.0
// ============================================================================
package chmod_pkg;

   localparam int TRIG_WIDTH          = 18;
   localparam int TRIG_FRAC           = 17;
   localparam int DEFAULT_PHASE_WIDTH = 12;

   localparam real c_two_pi = 6.283185307179586;

   // Elaboration-time table entry: round-half-away-from-zero of full-scale trig.
   function automatic logic signed [TRIG_WIDTH-1:0] trig_entry(
      input int idx,
      input int depth,
      input bit want_sin
   );
      real ang;
      real val;
      int  r;
      ang = c_two_pi * $itor(idx) / $itor(depth);
      val = $itor((1 << TRIG_FRAC) - 1) * (want_sin ? $sin(ang) : $cos(ang));
      r   = (val >= 0.0) ? $rtoi(val + 0.5) : -$rtoi(0.5 - val);
      return TRIG_WIDTH'(r);
   endfunction

   function automatic logic signed [63:0] round_sat(
      input logic signed [63:0] sum,
      input int unsigned        width
   );
      logic signed [63:0] v;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      v  = (sum + (64'sd1 <<< (TRIG_FRAC - 1))) >>> TRIG_FRAC;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (v > hi)
         v = hi;
      else if (v < lo)
         v = lo;
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rx_channel_demodulator_if.sv
`default_nettype none
// ============================================================================
//  Module   : rx_channel_demodulator_if
//  Purpose  : Sample-in / sample-out handshake and NCO increment load bundle.
//  Revision : 1.0
// ============================================================================
interface rx_channel_demodulator_if
   import chmod_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int PHASE_WIDTH = DEFAULT_PHASE_WIDTH
);
   logic signed [WIDTH-1:0]  i_inph;
   logic signed [WIDTH-1:0]  i_quad;
   logic                     i_valid;
   logic                     o_ready;
   logic [PHASE_WIDTH-1:0]   i_phase_inc;
   logic                     i_phase_inc_valid;
   logic signed [WIDTH-1:0]  o_inph;
   logic signed [WIDTH-1:0]  o_quad;
   logic                     o_valid;
   logic                     i_ready;

   modport slave (
      input  i_inph, i_quad, i_valid, i_phase_inc, i_phase_inc_valid, i_ready,
      output o_ready, o_inph, o_quad, o_valid
   );

   modport master (
      output i_inph, i_quad, i_valid, i_phase_inc, i_phase_inc_valid, i_ready,
      input  o_ready, o_inph, o_quad, o_valid
   );
endinterface
`default_nettype wire

// File: rtl/rx_chmod_dds.sv
`default_nettype none
// ============================================================================
//  Module   : rx_chmod_dds
//  Purpose  : NCO with increment register, phase accumulator and cos/sin LUT;
//             trig output registered one cycle after each advance.
//  Revision : 1.0
// ============================================================================
module rx_chmod_dds
   import chmod_pkg::*;
#(
   parameter int PHASE_WIDTH = DEFAULT_PHASE_WIDTH
) (
   input  wire logic                         i_clock,
   input  wire logic                         i_reset,
   input  wire logic                         i_advance,
   input  wire logic [PHASE_WIDTH-1:0]       i_phase_inc,
   input  wire logic                         i_phase_inc_valid,
   output logic signed [TRIG_WIDTH-1:0]      o_cos,
   output logic signed [TRIG_WIDTH-1:0]      o_sin
);

   localparam int c_depth = 2 ** PHASE_WIDTH;

   logic [PHASE_WIDTH-1:0]          r_phase;
   logic [PHASE_WIDTH-1:0]          r_inc;
   logic signed [TRIG_WIDTH-1:0]    r_cos;
   logic signed [TRIG_WIDTH-1:0]    r_sin;
   logic signed [TRIG_WIDTH-1:0]    w_cos_lut [c_depth];
   logic signed [TRIG_WIDTH-1:0]    w_sin_lut [c_depth];

   for (genvar g = 0; g < c_depth; g++) begin : g_lut
      localparam logic signed [TRIG_WIDTH-1:0] c_cos = trig_entry(g, c_depth, 1'b0);
      localparam logic signed [TRIG_WIDTH-1:0] c_sin = trig_entry(g, c_depth, 1'b1);
      assign w_cos_lut[g] = c_cos;
      assign w_sin_lut[g] = c_sin;
   end

   // Increment loads regardless of stalls; an advance in the same cycle still
   // sees the previous increment because r_inc is read before it updates.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_phase <= '0;
         r_inc   <= '0;
         r_cos   <= '0;
         r_sin   <= '0;
      end else begin
         if (i_phase_inc_valid)
            r_inc <= i_phase_inc;
         if (i_advance) begin
            r_phase <= r_phase + r_inc;
            r_cos   <= w_cos_lut[r_phase];
            r_sin   <= w_sin_lut[r_phase];
         end
      end
   end

   assign o_cos = r_cos;
   assign o_sin = r_sin;

endmodule
`default_nettype wire

// File: rtl/rx_channel_demodulator.sv
`default_nettype none
// ============================================================================
//  Module   : rx_channel_demodulator
//  Purpose  : Four-stage conjugate NCO mixer bringing a received channel to
//             baseband, with valid/ready flow control and stall support.
//  Revision : 1.0
// ============================================================================
module rx_channel_demodulator
   import chmod_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int PHASE_WIDTH = DEFAULT_PHASE_WIDTH
) (
   input  wire logic                   i_clock,
   input  wire logic                   i_reset,
   rx_channel_demodulator_if.slave     bus
);

   localparam int c_prod_w = WIDTH + TRIG_WIDTH;
   localparam int c_sum_w  = WIDTH + TRIG_WIDTH + 1;

   logic                            w_en;
   logic                            w_accept;
   logic signed [TRIG_WIDTH-1:0]    w_cos;
   logic signed [TRIG_WIDTH-1:0]    w_sin;

   logic                            r_v1, r_v2, r_v3, r_valid_out;
   logic signed [WIDTH-1:0]         r_i1, r_q1;
   logic signed [c_prod_w-1:0]      r_p_ic, r_p_qs, r_p_qc, r_p_is;
   logic signed [c_sum_w-1:0]       r_sum_i, r_sum_q;
   logic signed [WIDTH-1:0]         r_out_i, r_out_q;

   assign w_en         = !r_valid_out || bus.i_ready;
   assign w_accept     = bus.i_valid && w_en && !i_reset;
   assign bus.o_ready  = w_en && !i_reset;

   rx_chmod_dds #(
      .PHASE_WIDTH (PHASE_WIDTH)
   ) u_dds (
      .i_clock           (i_clock),
      .i_reset           (i_reset),
      .i_advance         (w_accept),
      .i_phase_inc       (bus.i_phase_inc),
      .i_phase_inc_valid (bus.i_phase_inc_valid),
      .o_cos             (w_cos),
      .o_sin             (w_sin)
   );

   // Stage 1 captures the sample in the same edge the NCO registers its phase,
   // so stage-1 data and w_cos/w_sin line up.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_v1        <= 1'b0;
         r_v2        <= 1'b0;
         r_v3        <= 1'b0;
         r_valid_out <= 1'b0;
         r_i1        <= '0;
         r_q1        <= '0;
         r_p_ic      <= '0;
         r_p_qs      <= '0;
         r_p_qc      <= '0;
         r_p_is      <= '0;
         r_sum_i     <= '0;
         r_sum_q     <= '0;
         r_out_i     <= '0;
         r_out_q     <= '0;
      end else if (w_en) begin
         r_v1        <= w_accept;
         r_i1        <= bus.i_inph;
         r_q1        <= bus.i_quad;

         r_v2        <= r_v1;
         r_p_ic      <= c_prod_w'(r_i1) * c_prod_w'(w_cos);
         r_p_qs      <= c_prod_w'(r_q1) * c_prod_w'(w_sin);
         r_p_qc      <= c_prod_w'(r_q1) * c_prod_w'(w_cos);
         r_p_is      <= c_prod_w'(r_i1) * c_prod_w'(w_sin);

         r_v3        <= r_v2;
         r_sum_i     <= c_sum_w'(r_p_ic) + c_sum_w'(r_p_qs);
         r_sum_q     <= c_sum_w'(r_p_qc) - c_sum_w'(r_p_is);

         r_valid_out <= r_v3;
         r_out_i     <= WIDTH'(round_sat(64'(r_sum_i), WIDTH));
         r_out_q     <= WIDTH'(round_sat(64'(r_sum_q), WIDTH));
      end
   end

   assign bus.o_valid = r_valid_out;
   assign bus.o_inph  = r_out_i;
   assign bus.o_quad  = r_out_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_channel_demodulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rx_channel_demodulator
//  Purpose  : Directed self-checking bench for rx_channel_demodulator.
//  Revision : 1.0
// ============================================================================
module tb_rx_channel_demodulator;

   localparam int c_w  = 16;
   localparam int c_pw = 12;

   logic clock;
   logic reset;
   int   n_checks = 0;
   int   n_bad    = 0;
   int   got_i[$], got_q[$], exp_i[$], exp_q[$];

   rx_channel_demodulator_if #(.WIDTH(c_w), .PHASE_WIDTH(c_pw)) bus ();

   rx_channel_demodulator #(
      .WIDTH       (c_w),
      .PHASE_WIDTH (c_pw)
   ) dut (
      .i_clock (clock),
      .i_reset (reset),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Record each handshake just before the edge that completes it.
   always @(negedge clock) begin
      if (bus.o_valid && bus.i_ready) begin
         got_i.push_back(int'(bus.o_inph));
         got_q.push_back(int'(bus.o_quad));
      end
   end

   task automatic check_val(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      bus.i_valid = 1'b0;
      bus.i_phase_inc_valid = 1'b0;
      bus.i_ready = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      got_i.delete(); got_q.delete(); exp_i.delete(); exp_q.delete();
   endtask

   task automatic load_inc(input int v);
      bus.i_phase_inc = c_pw'(v);
      bus.i_phase_inc_valid = 1'b1;
      cyc();
      bus.i_phase_inc_valid = 1'b0;
   endtask

   task automatic send(input int i, input int q);
      int n = 0;
      bus.i_inph  = c_w'(i);
      bus.i_quad  = c_w'(q);
      bus.i_valid = 1'b1;
      @(negedge clock);
      while (!bus.o_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (n >= 50) check_val("send_timeout", longint'(n), 0);
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      bus.i_valid = 1'b0;
   endtask

   task automatic expect_out(input int i, input int q);
      exp_i.push_back(i);
      exp_q.push_back(q);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (got_i.size() < exp_i.size() && n < 40) begin
         cyc();
         n++;
      end
      repeat (3) cyc();
      check_val({tag, "_count"}, longint'(got_i.size()), longint'(exp_i.size()));
      for (int k = 0; k < exp_i.size() && k < got_i.size(); k++) begin
         check_val($sformatf("%s_i%0d", tag, k), longint'(got_i[k]), longint'(exp_i[k]));
         check_val($sformatf("%s_q%0d", tag, k), longint'(got_q[k]), longint'(exp_q[k]));
      end
      got_i.delete(); got_q.delete(); exp_i.delete(); exp_q.delete();
   endtask

   initial begin
      reset = 1'b1;
      bus.i_inph = '0;
      bus.i_quad = '0;
      bus.i_valid = 1'b0;
      bus.i_phase_inc = '0;
      bus.i_phase_inc_valid = 1'b0;
      bus.i_ready = 1'b1;
      cyc();
      cyc();
      check_val("rst_o_valid", longint'(bus.o_valid), 0);
      check_val("rst_o_inph",  longint'(bus.o_inph), 0);
      check_val("rst_o_quad",  longint'(bus.o_quad), 0);
      check_val("rst_o_ready", longint'(bus.o_ready), 0);
      reset = 1'b0;
      #1;
      check_val("ready_after_rst", longint'(bus.o_ready), 1);

      // Zero increment passes the sample through; latency of four cycles.
      send(1000, -500);
      idle();
      check_val("lat_c1", longint'(bus.o_valid), 0);
      for (int k = 2; k <= 4; k++) begin
         cyc();
         check_val($sformatf("lat_c%0d", k), longint'(bus.o_valid), (k == 4) ? 1 : 0);
      end
      expect_out(1000, -500);
      drain("pass");

      // Quarter-turn steps rotate the conjugate output clockwise.
      load_inc(1024);
      for (int k = 0; k < 4; k++) send(1000, 0);
      idle();
      expect_out(1000, 0);
      expect_out(0, -1000);
      expect_out(-1000, 0);
      expect_out(0, 1000);
      drain("quarter");

      // Eighth-turn with full-scale input saturates the in-phase output.
      apply_reset();
      load_inc(512);
      send(100, 0);
      send(32767, 32767);
      idle();
      expect_out(100, 0);
      expect_out(32767, 0);
      drain("sat");

      // Downstream stall with a full pipeline.
      apply_reset();
      for (int k = 1; k <= 4; k++) send(100 * k, -50 * k);
      bus.i_inph  = c_w'(500);
      bus.i_quad  = c_w'(-250);
      bus.i_ready = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         check_val($sformatf("stall_ready%0d", k), longint'(bus.o_ready), 0);
         check_val($sformatf("stall_valid%0d", k), longint'(bus.o_valid), 1);
         check_val($sformatf("stall_inph%0d", k),  longint'(bus.o_inph), 100);
         check_val($sformatf("stall_quad%0d", k),  longint'(bus.o_quad), -50);
         if (k < 3) cyc();
      end
      bus.i_ready = 1'b1;
      send(500, -250);
      send(600, -300);
      idle();
      for (int k = 1; k <= 6; k++) expect_out(100 * k, -50 * k);
      drain("stall");

      // Increment load coincident with an accept takes effect one accept later.
      apply_reset();
      load_inc(1024);
      bus.i_phase_inc = c_pw'(2048);
      bus.i_phase_inc_valid = 1'b1;
      send(1000, 0);
      bus.i_phase_inc_valid = 1'b0;
      send(1000, 0);
      send(1000, 0);
      idle();
      expect_out(1000, 0);
      expect_out(0, -1000);
      expect_out(0, 1000);
      drain("incload");

      // Accumulator wrap 4095 + 1 -> 0.
      apply_reset();
      load_inc(4095);
      bus.i_phase_inc = c_pw'(1);
      bus.i_phase_inc_valid = 1'b1;
      send(1000, 0);
      bus.i_phase_inc_valid = 1'b0;
      send(1000, 0);
      send(1000, 0);
      idle();
      expect_out(1000, 0);
      expect_out(1000, 2);
      expect_out(1000, 0);
      drain("wrap");

      // Reset with three samples in flight.
      apply_reset();
      load_inc(1024);
      send(1000, 0);
      send(500, 0);
      send(200, 0);
      idle();
      reset = 1'b1;
      cyc();
      check_val("midrst_valid", longint'(bus.o_valid), 0);
      check_val("midrst_ready", longint'(bus.o_ready), 0);
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc();
         check_val($sformatf("midrst_quiet%0d", k), longint'(bus.o_valid), 0);
      end
      check_val("midrst_none", longint'(got_i.size()), 0);
      load_inc(1024);
      send(1000, 0);
      idle();
      expect_out(1000, 0);
      drain("midrst");

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected done");
      $fatal(1);
   end

endmodule
`default_nettype wire
